asrv32_decoder_pipe: RTL
========================

Name: asrv32_decoder_pipe

Overview:
Registered RV32I/E instruction decode stage with a valid/ready handshake, pipeline flush and an optional M-extension decode path. It sits between fetch and execute. It replaces the free-running decode register with a stallable pipeline register that carries the PC and a valid bit alongside the decoded fields. Architectural variant and extension support are selected by parameters.

Parameters:
RV32E, 0, 1 = 16-register base ISA; any used register address with bit 4 set is illegal.
M_EXT, 1, 1 = decode MUL/DIV group; 0 = funct7 0000001 R-type instructions are illegal.
PC_WIDTH, 32, width of the PC carried through the stage.

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_inst  in  32  instruction from fetch
i_pc  in  PC_WIDTH  PC of i_inst
i_valid  in  1  fetch presents an instruction
o_ready  out  1  stage can accept an instruction this cycle
i_ready  in  1  execute accepts the output this cycle
i_flush  in  1  kill the held instruction and any instruction accepted this cycle
o_valid  out  1  output fields hold a live instruction
o_pc  out  PC_WIDTH  registered PC
o_rs1_addr / o_rs2_addr / o_rd_addr  out  5 each  registered register addresses
o_imm  out  32  sign/zero-extended immediate
o_funct3  out  3  registered funct3
o_opcode  out  `OPCODE_WIDTH  one-hot opcode class
o_alu_op  out  `ALU_WIDTH  one-hot ALU operation
o_mul_op  out  8  one-hot [0]MUL [1]MULH [2]MULHSU [3]MULHU [4]DIV [5]DIVU [6]REM [7]REMU
o_exception  out  `EXCEPTION_WIDTH  ILLEGAL/ECALL/EBREAK/MRET

Behaviour:
- Reset (async, i_rst_n=0): o_valid=0 and every other registered output = 0, immediately and independent of the clock.
- o_ready = !o_valid || i_ready (combinational). There is no skid buffer.
- Accept = i_valid && o_ready. On accept, all output fields load the decode of i_inst/i_pc next edge, and o_valid <= 1.
- If o_valid && i_ready && !accept: o_valid <= 0 and the fields hold.
- If o_valid && !i_ready: all outputs hold stable. This holds even if i_valid or i_inst changes.
- i_flush has highest priority. Next edge o_valid <= 0 regardless of accept or i_ready. Fields may update but are don't-care. o_ready is unaffected by i_flush.
- Latency: 1 cycle from accept to o_valid. Back-to-back throughput is 1 instruction/cycle when i_ready=1.
- Opcode decode: the 11 classes (RTYPE, ITYPE, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, SYSTEM, FENCE) are one-hot. An unknown opcode gives all-zero o_opcode and ILLEGAL.
- R-type, funct7=0000000: ALU op from funct3 (ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND).
- R-type, funct7=0100000: legal only for funct3 000 (SUB) and 101 (SRA); otherwise ILLEGAL.
- R-type, funct7=0000001: with M_EXT=1, o_mul_op bit = funct3 and o_alu_op = 0. With M_EXT=0, ILLEGAL.
- R-type, any other funct7: ILLEGAL.
- o_mul_op is all-zero for every non-M instruction.
- I-type: ADD for funct3=000 (there is no SUBI).
- I-type shifts: SLLI is illegal if inst[31:25] != 0. SRLI/SRAI are illegal if inst[31:25] is not 0000000/0100000; inst[30] selects SRA.
- BRANCH: funct3 maps to EQ/NEQ/SLT/GE/SLTU/GEU. funct3 010/011 are ILLEGAL.
- All other classes: ADD.
- Immediates by class:
  - I/LOAD/JALR: sign-extended [31:20].
  - STORE: {[31:25],[11:7]} sign-extended.
  - BRANCH: B-format, bit 0 = 0.
  - JAL: J-format, bit 0 = 0.
  - LUI/AUIPC: {[31:12],12'h0}.
  - SYSTEM/FENCE: zero-extended [31:20].
  - Otherwise: 0.
- SYSTEM with funct3=000: ECALL if [21:20]=00, EBREAK if 01, MRET if 10. Value 11 is ILLEGAL.
- RV32E=1: ILLEGAL if a used register field (rd/rs1/rs2 as the format requires) has bit 4 set.
- Every instruction with ILLEGAL set still produces o_valid=1, so the trap propagates. Flush is the only thing that drops an instruction.

Test Plan:
- Reset mid-stream with o_valid=1 -> all outputs 0 asynchronously. After release with i_valid=0, o_valid stays 0 and o_ready=1.
- 0x00510093 (ADDI x1,x2,5), i_pc=0x100, i_ready=1 -> next cycle o_valid=1, ITYPE, ADD, o_imm=5, o_rd=1, o_rs1=2, o_pc=0x100.
- 0x022081B3 (MUL x3,x1,x2): M_EXT=1 -> o_mul_op=8'h01, o_alu_op=0, no exception. M_EXT=0 -> ILLEGAL=1.
- 0x40335293 (SRAI) -> SRA, o_imm=0x403. 0x02031293 -> ILLEGAL. 0x00000073 -> ECALL. 0x00208833 with RV32E=1 -> ILLEGAL; with RV32E=0 -> legal ADD.
- Stall: hold i_ready=0 for 3 cycles while i_inst changes -> outputs stable and o_ready=0. Release -> the next instruction loads one cycle later.
- Flush: assert i_flush together with accept and i_ready=0 -> o_valid=0 next cycle. Next accept proceeds normally.

Source files
------------

// File: rtl/asrv32_decoder_pipe.sv
// RV32I/E decode stage: a stallable pipeline register carrying the PC, a valid bit and the
// decoded fields between fetch and execute, with flush and an optional M-extension decode.
`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 11
`endif
`ifndef ALU_WIDTH
`define ALU_WIDTH 14
`endif
`ifndef EXCEPTION_WIDTH
`define EXCEPTION_WIDTH 4
`endif

module asrv32_decoder_pipe #(
    parameter bit          RV32E    = 1'b0,
    parameter bit          M_EXT    = 1'b1,
    parameter int unsigned PC_WIDTH = 32
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic [31:0]                 i_inst,
    input  logic [PC_WIDTH-1:0]         i_pc,
    input  logic                        i_valid,
    output logic                        o_ready,
    input  logic                        i_ready,
    input  logic                        i_flush,
    output logic                        o_valid,
    output logic [PC_WIDTH-1:0]         o_pc,
    output logic [4:0]                  o_rs1_addr,
    output logic [4:0]                  o_rs2_addr,
    output logic [4:0]                  o_rd_addr,
    output logic [31:0]                 o_imm,
    output logic [2:0]                  o_funct3,
    output logic [`OPCODE_WIDTH-1:0]    o_opcode,
    output logic [`ALU_WIDTH-1:0]       o_alu_op,
    output logic [7:0]                  o_mul_op,
    output logic [`EXCEPTION_WIDTH-1:0] o_exception
);

    localparam int unsigned OpRtype  = 0;
    localparam int unsigned OpItype  = 1;
    localparam int unsigned OpLoad   = 2;
    localparam int unsigned OpStore  = 3;
    localparam int unsigned OpBranch = 4;
    localparam int unsigned OpJal    = 5;
    localparam int unsigned OpJalr   = 6;
    localparam int unsigned OpLui    = 7;
    localparam int unsigned OpAuipc  = 8;
    localparam int unsigned OpSystem = 9;
    localparam int unsigned OpFence  = 10;

    localparam int unsigned AluAdd  = 0;
    localparam int unsigned AluSub  = 1;
    localparam int unsigned AluSlt  = 2;
    localparam int unsigned AluSltu = 3;
    localparam int unsigned AluXor  = 4;
    localparam int unsigned AluOr   = 5;
    localparam int unsigned AluAnd  = 6;
    localparam int unsigned AluSll  = 7;
    localparam int unsigned AluSrl  = 8;
    localparam int unsigned AluSra  = 9;
    localparam int unsigned AluEq   = 10;
    localparam int unsigned AluNeq  = 11;
    localparam int unsigned AluGe   = 12;
    localparam int unsigned AluGeu  = 13;

    localparam int unsigned ExcIllegal = 0;
    localparam int unsigned ExcEcall   = 1;
    localparam int unsigned ExcEbreak  = 2;
    localparam int unsigned ExcMret    = 3;

    localparam logic [6:0] OpcRtype  = 7'b0110011;
    localparam logic [6:0] OpcItype  = 7'b0010011;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcJalr   = 7'b1100111;
    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;
    localparam logic [6:0] OpcSystem = 7'b1110011;
    localparam logic [6:0] OpcFence  = 7'b0001111;

    logic [6:0] opc;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rd, rs1, rs2;
    logic [31:0] imm_i;

    assign opc    = i_inst[6:0];
    assign rd     = i_inst[11:7];
    assign funct3 = i_inst[14:12];
    assign rs1    = i_inst[19:15];
    assign rs2    = i_inst[24:20];
    assign funct7 = i_inst[31:25];
    assign imm_i  = {{20{i_inst[31]}}, i_inst[31:20]};

    logic [`OPCODE_WIDTH-1:0]    opcode_d;
    logic [`ALU_WIDTH-1:0]       alu_d;
    logic [7:0]                  mul_d;
    logic [31:0]                 imm_d;
    logic [`EXCEPTION_WIDTH-1:0] exc_d;
    logic                        illegal;
    logic                        use_rd, use_rs1, use_rs2;

    always_comb begin
        opcode_d = '0;
        alu_d    = '0;
        mul_d    = '0;
        imm_d    = '0;
        exc_d    = '0;
        illegal  = 1'b0;
        use_rd   = 1'b0;
        use_rs1  = 1'b0;
        use_rs2  = 1'b0;
        case (opc)
            OpcRtype: begin
                opcode_d[OpRtype] = 1'b1;
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                case (funct7)
                    7'b0000000: begin
                        unique case (funct3)
                            3'b000: alu_d[AluAdd]  = 1'b1;
                            3'b001: alu_d[AluSll]  = 1'b1;
                            3'b010: alu_d[AluSlt]  = 1'b1;
                            3'b011: alu_d[AluSltu] = 1'b1;
                            3'b100: alu_d[AluXor]  = 1'b1;
                            3'b101: alu_d[AluSrl]  = 1'b1;
                            3'b110: alu_d[AluOr]   = 1'b1;
                            3'b111: alu_d[AluAnd]  = 1'b1;
                        endcase
                    end
                    7'b0100000: begin
                        if (funct3 == 3'b000) begin
                            alu_d[AluSub] = 1'b1;
                        end else if (funct3 == 3'b101) begin
                            alu_d[AluSra] = 1'b1;
                        end else begin
                            illegal = 1'b1;
                        end
                    end
                    7'b0000001: begin
                        if (M_EXT) begin
                            mul_d[funct3] = 1'b1;
                        end else begin
                            illegal = 1'b1;
                        end
                    end
                    default: illegal = 1'b1;
                endcase
            end
            OpcItype: begin
                opcode_d[OpItype] = 1'b1;
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                imm_d   = imm_i;
                unique case (funct3)
                    3'b000: alu_d[AluAdd]  = 1'b1;
                    3'b010: alu_d[AluSlt]  = 1'b1;
                    3'b011: alu_d[AluSltu] = 1'b1;
                    3'b100: alu_d[AluXor]  = 1'b1;
                    3'b110: alu_d[AluOr]   = 1'b1;
                    3'b111: alu_d[AluAnd]  = 1'b1;
                    3'b001: begin
                        alu_d[AluSll] = 1'b1;
                        illegal       = (funct7 != 7'b0000000);
                    end
                    3'b101: begin
                        // The shift op is still reported when the funct7 pattern is bad.
                        if (i_inst[30]) alu_d[AluSra] = 1'b1;
                        else            alu_d[AluSrl] = 1'b1;
                        illegal = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
                    end
                endcase
            end
            OpcLoad: begin
                opcode_d[OpLoad] = 1'b1;
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                imm_d   = imm_i;
                alu_d[AluAdd] = 1'b1;
            end
            OpcStore: begin
                opcode_d[OpStore] = 1'b1;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                imm_d   = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
                alu_d[AluAdd] = 1'b1;
            end
            OpcBranch: begin
                opcode_d[OpBranch] = 1'b1;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                imm_d   = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25],
                           i_inst[11:8], 1'b0};
                case (funct3)
                    3'b000:  alu_d[AluEq]   = 1'b1;
                    3'b001:  alu_d[AluNeq]  = 1'b1;
                    3'b100:  alu_d[AluSlt]  = 1'b1;
                    3'b101:  alu_d[AluGe]   = 1'b1;
                    3'b110:  alu_d[AluSltu] = 1'b1;
                    3'b111:  alu_d[AluGeu]  = 1'b1;
                    default: illegal        = 1'b1;
                endcase
            end
            OpcJal: begin
                opcode_d[OpJal] = 1'b1;
                use_rd = 1'b1;
                imm_d  = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20],
                          i_inst[30:21], 1'b0};
                alu_d[AluAdd] = 1'b1;
            end
            OpcJalr: begin
                opcode_d[OpJalr] = 1'b1;
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                imm_d   = imm_i;
                alu_d[AluAdd] = 1'b1;
            end
            OpcLui, OpcAuipc: begin
                opcode_d[(opc == OpcLui) ? OpLui : OpAuipc] = 1'b1;
                use_rd = 1'b1;
                imm_d  = {i_inst[31:12], 12'h000};
                alu_d[AluAdd] = 1'b1;
            end
            OpcSystem: begin
                opcode_d[OpSystem] = 1'b1;
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                imm_d   = {20'h00000, i_inst[31:20]};
                alu_d[AluAdd] = 1'b1;
                if (funct3 == 3'b000) begin
                    unique case (i_inst[21:20])
                        2'b00: exc_d[ExcEcall]  = 1'b1;
                        2'b01: exc_d[ExcEbreak] = 1'b1;
                        2'b10: exc_d[ExcMret]   = 1'b1;
                        2'b11: illegal          = 1'b1;
                    endcase
                end
            end
            OpcFence: begin
                opcode_d[OpFence] = 1'b1;
                imm_d = {20'h00000, i_inst[31:20]};
                alu_d[AluAdd] = 1'b1;
            end
            default: illegal = 1'b1;
        endcase

        // Only register fields the format actually reads are range-checked.
        if (RV32E && ((use_rd && rd[4]) || (use_rs1 && rs1[4]) || (use_rs2 && rs2[4]))) begin
            illegal = 1'b1;
        end
        exc_d[ExcIllegal] = illegal;
    end

    logic accept;

    assign o_ready = !o_valid || i_ready;
    assign accept  = i_valid && o_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid     <= 1'b0;
            o_pc        <= '0;
            o_rs1_addr  <= '0;
            o_rs2_addr  <= '0;
            o_rd_addr   <= '0;
            o_imm       <= '0;
            o_funct3    <= '0;
            o_opcode    <= '0;
            o_alu_op    <= '0;
            o_mul_op    <= '0;
            o_exception <= '0;
        end else begin
            if (accept) begin
                o_pc        <= i_pc;
                o_rs1_addr  <= rs1;
                o_rs2_addr  <= rs2;
                o_rd_addr   <= rd;
                o_imm       <= imm_d;
                o_funct3    <= funct3;
                o_opcode    <= opcode_d;
                o_alu_op    <= alu_d;
                o_mul_op    <= mul_d;
                o_exception <= exc_d;
            end
            if (i_flush) begin
                o_valid <= 1'b0;
            end else if (accept) begin
                o_valid <= 1'b1;
            end else if (i_ready) begin
                o_valid <= 1'b0;
            end
        end
    end

endmodule
